// File: rtl/text_grid_show.sv
// Character-grid renderer: ROWS x COLS buffer with inverse attribute and cursor highlight,
// walked cell by cell to feed the char-draw block over the show_char_flag / show_char_done handshake.
module text_grid_show #(
    parameter int unsigned COLS         = 20,
    parameter int unsigned ROWS         = 5,
    parameter bit          FONT16       = 1'b1,
    parameter int unsigned X0           = 1,
    parameter int unsigned Y0           = 0,
    parameter bit          AUTO_REFRESH = 1'b1,
    parameter logic [15:0] FG_COLOR     = 16'h0000,
    parameter logic [15:0] BG_COLOR     = 16'hAF7D,
    parameter logic [15:0] HL_FG        = 16'hFFFF,
    parameter logic [15:0] HL_BG        = 16'h815B,
    parameter logic [15:0] CUR_FG       = 16'hFFFF,
    parameter logic [15:0] CUR_BG       = 16'hFA20,
    localparam int unsigned NCELLS      = ROWS * COLS,
    localparam int unsigned AW          = (NCELLS > 1) ? $clog2(NCELLS) : 1
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          init_done,
    input  logic          show_char_done,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          refresh_req,
    input  logic          cursor_en,
    input  logic [3:0]    cursor_row,
    input  logic [4:0]    cursor_col,
    output logic          en_size,
    output logic          show_char_flag,
    output logic [6:0]    ascii_num,
    output logic [8:0]    start_x,
    output logic [8:0]    start_y,
    output logic [15:0]   front_color,
    output logic [15:0]   background_color,
    output logic          busy,
    output logic          frame_done
);

    localparam int unsigned CHAR_W = FONT16 ? 8 : 6;
    localparam int unsigned CHAR_H = FONT16 ? 16 : 12;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SETUP = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    localparam logic [AW-1:0] LAST_IDX = AW'(NCELLS - 1);
    localparam logic [4:0]    LAST_COL = 5'(COLS - 1);

    logic [7:0]    mem_q [NCELLS];
    logic [7:0]    rd_data_q;
    logic          wr_ok;

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [3:0]    row_q, row_d;
    logic [4:0]    col_q, col_d;
    logic          pending_q, pending_d;
    logic          flag_q, flag_d;
    logic [6:0]    ascii_q, ascii_d;
    logic [8:0]    x_q, x_d;
    logic [8:0]    y_q, y_d;
    logic [15:0]   fg_q, fg_d;
    logic [15:0]   bg_q, bg_d;
    logic          busy_q, busy_d;
    logic          fdone_q, fdone_d;
    logic          frame_start;
    logic          cur_hit;

    assign wr_ok = wr_en && ({1'b0, wr_addr} < (AW + 1)'(NCELLS));

    // Buffer: unreset storage, read-first synchronous read of the current cell
    always_ff @(posedge sys_clk) begin
        if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= mem_q[idx_q];
    end

    assign cur_hit = cursor_en && (cursor_row == row_q) && (cursor_col == col_q);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        row_d       = row_q;
        col_d       = col_q;
        pending_d   = pending_q;
        flag_d      = 1'b0;
        ascii_d     = ascii_q;
        x_d         = x_q;
        y_d         = y_q;
        fg_d        = fg_q;
        bg_d        = bg_q;
        fdone_d     = 1'b0;
        frame_start = 1'b0;

        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                row_d = '0;
                col_d = '0;
                if (init_done && (AUTO_REFRESH || pending_q)) begin
                    state_d     = S_LOAD;
                    frame_start = 1'b1;
                end
            end
            S_LOAD: state_d = S_SETUP;
            S_SETUP: begin
                ascii_d = rd_data_q[6:0];
                x_d     = 9'(X0) + 9'(col_q * CHAR_W);
                y_d     = 9'(Y0) + 9'(row_q * CHAR_H);
                if (cur_hit) begin
                    fg_d = CUR_FG;
                    bg_d = CUR_BG;
                end else if (rd_data_q[7]) begin
                    fg_d = HL_FG;
                    bg_d = HL_BG;
                end else begin
                    fg_d = FG_COLOR;
                    bg_d = BG_COLOR;
                end
                flag_d  = 1'b1;
                state_d = S_ISSUE;
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (show_char_done) begin
                    state_d = S_LOAD;
                    if (idx_q == LAST_IDX) begin
                        fdone_d = 1'b1;
                        idx_d   = '0;
                        row_d   = '0;
                        col_d   = '0;
                        if (AUTO_REFRESH || pending_q) begin
                            frame_start = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (col_q == LAST_COL) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Losing init_done aborts the frame but keeps any queued request
        if (!init_done) begin
            state_d     = S_IDLE;
            flag_d      = 1'b0;
            fdone_d     = 1'b0;
            idx_d       = '0;
            row_d       = '0;
            col_d       = '0;
            frame_start = 1'b0;
        end

        if (refresh_req) begin
            pending_d = 1'b1;
        end else if (frame_start) begin
            pending_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            pending_q <= 1'b0;
            flag_q    <= 1'b0;
            ascii_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            fg_q      <= FG_COLOR;
            bg_q      <= BG_COLOR;
            busy_q    <= 1'b0;
            fdone_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            row_q     <= row_d;
            col_q     <= col_d;
            pending_q <= pending_d;
            flag_q    <= flag_d;
            ascii_q   <= ascii_d;
            x_q       <= x_d;
            y_q       <= y_d;
            fg_q      <= fg_d;
            bg_q      <= bg_d;
            busy_q    <= busy_d;
            fdone_q   <= fdone_d;
        end
    end

    assign en_size          = FONT16;
    assign show_char_flag   = flag_q;
    assign ascii_num        = ascii_q;
    assign start_x          = x_q;
    assign start_y          = y_q;
    assign front_color      = fg_q;
    assign background_color = bg_q;
    assign busy             = busy_q;
    assign frame_done       = fdone_q;

endmodule

// File: tb/tb_text_grid_show.sv
// Bench for text_grid_show: plays the char-draw block with random done delays and
// checks every drawn cell against a grid model of buffer contents, attributes and cursor.
module tb_text_grid_show;

    localparam int COLS = 20;
    localparam int ROWS = 5;
    localparam int NC   = ROWS * COLS;
    localparam int AW   = 7;
    localparam int X0   = 1;
    localparam int Y0   = 0;
    localparam logic [15:0] FG  = 16'h0000;
    localparam logic [15:0] BG  = 16'hAF7D;
    localparam logic [15:0] HLF = 16'hFFFF;
    localparam logic [15:0] HLB = 16'h815B;
    localparam logic [15:0] CF  = 16'hFFFF;
    localparam logic [15:0] CB  = 16'hFA20;

    logic          sys_clk;
    logic          sys_rst_n;
    logic          init_done;
    logic          show_char_done;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          refresh_req;
    logic          cursor_en;
    logic [3:0]    cursor_row;
    logic [4:0]    cursor_col;
    logic          en_size;
    logic          show_char_flag;
    logic [6:0]    ascii_num;
    logic [8:0]    start_x;
    logic [8:0]    start_y;
    logic [15:0]   front_color;
    logic [15:0]   background_color;
    logic          busy;
    logic          frame_done;

    text_grid_show #(
        .COLS(COLS), .ROWS(ROWS), .FONT16(1'b1), .X0(X0), .Y0(Y0), .AUTO_REFRESH(1'b0)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_done(init_done),
        .show_char_done(show_char_done), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .refresh_req(refresh_req), .cursor_en(cursor_en), .cursor_row(cursor_row),
        .cursor_col(cursor_col), .en_size(en_size), .show_char_flag(show_char_flag),
        .ascii_num(ascii_num), .start_x(start_x), .start_y(start_y), .front_color(front_color),
        .background_color(background_color), .busy(busy), .frame_done(frame_done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int flag_cnt = 0;
    int fd_cnt   = 0;

    always @(posedge sys_clk) begin
        cyc <= cyc + 1;
        if (show_char_flag === 1'b1) flag_cnt <= flag_cnt + 1;
        if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    end

    // Grid model and cursor model
    logic [7:0] mdl_buf [NC];
    bit         m_cen;
    int         m_cr;
    int         m_cc;

    // Captured draw requests of the most recent frame
    logic [6:0]  r_ascii [NC];
    logic [8:0]  r_x     [NC];
    logic [8:0]  r_y     [NC];
    logic [15:0] r_fg    [NC];
    logic [15:0] r_bg    [NC];
    int          r_cyc   [NC];

    function automatic logic [56:0] exp_cell(input int i);
        int row = i / COLS;
        int col = i % COLS;
        logic [8:0]  x = 9'((X0 + col * 8) % 512);
        logic [8:0]  y = 9'((Y0 + row * 16) % 512);
        logic [15:0] f;
        logic [15:0] b;
        if (m_cen && m_cr == row && m_cc == col) begin
            f = CF; b = CB;
        end else if (mdl_buf[i][7]) begin
            f = HLF; b = HLB;
        end else begin
            f = FG; b = BG;
        end
        return {mdl_buf[i][6:0], x, y, f, b};
    endfunction

    task automatic write_cell(input int a, input logic [7:0] d);
        @(negedge sys_clk);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
        @(negedge sys_clk);
        wr_en = 1'b0;
        if (a < NC) mdl_buf[a] = d;
    endtask

    task automatic pulse_refresh();
        @(negedge sys_clk);
        refresh_req = 1'b1;
        @(negedge sys_clk);
        refresh_req = 1'b0;
    endtask

    task automatic set_cursor(input bit en, input int r, input int c);
        @(negedge sys_clk);
        cursor_en = en; cursor_row = 4'(r); cursor_col = 5'(c);
        m_cen = en; m_cr = r; m_cc = c;
    endtask

    // Acts as the char-draw block for ncells cells; returns observations only
    task automatic run_frame(input int ncells, input int dmin, input int dmax, input int req1, input int req2,
                             output int nserved, output bit tmo, output int unstable, output int badgap,
                             output int badpulse, output int fwait);
        int w, d, pd;
        logic [56:0] snap;
        nserved = 0; tmo = 0; unstable = 0; badgap = 0; badpulse = 0; pd = 0; fwait = 0;
        for (int i = 0; i < ncells; i++) begin
            w = 0;
            do begin @(negedge sys_clk); w++; end while (show_char_flag !== 1'b1 && w < 200);
            if (show_char_flag !== 1'b1) begin tmo = 1; return; end
            if (i == 0) fwait = w;
            snap = {ascii_num, start_x, start_y, front_color, background_color};
            r_ascii[i] = ascii_num; r_x[i] = start_x; r_y[i] = start_y;
            r_fg[i] = front_color; r_bg[i] = background_color; r_cyc[i] = cyc;
            if (i > 0 && (r_cyc[i] - r_cyc[i-1]) != pd + 3) badgap++;
            d = int'($urandom_range(dmax, dmin));
            if ((i == req1 || i == req2) && d < 2) d = 2;
            for (int k = 1; k <= d; k++) begin
                @(negedge sys_clk);
                if (k == 1 && show_char_flag !== 1'b0) badpulse++;
                refresh_req = ((i == req1 || i == req2) && k == 1);
                if ({ascii_num, start_x, start_y, front_color, background_color} !== snap) unstable++;
            end
            refresh_req = 1'b0;
            show_char_done = 1'b1;
            @(negedge sys_clk);
            show_char_done = 1'b0;
            pd = d;
            nserved++;
        end
    endtask

    int  n, ust, bg_, bp, fw, fl0, fd0, seen;
    bit  tmo;

    task automatic test_reset();
        sys_rst_n = 1'b0; init_done = 1'b0; show_char_done = 1'b0; wr_en = 1'b0; wr_addr = '0;
        wr_data = '0; refresh_req = 1'b0; cursor_en = 1'b0; cursor_row = '0; cursor_col = '0;
        m_cen = 0; m_cr = 0; m_cc = 0;
        repeat (3) @(negedge sys_clk);
        total++;
        if ({show_char_flag, ascii_num, start_x, start_y} !== 26'd0) begin
            $display("FAIL reset_pos: got flag/ascii/x/y=%h want 0", {show_char_flag, ascii_num, start_x, start_y});
        end else passed++;
        total++;
        if ({front_color, background_color} !== {FG, BG}) begin
            $display("FAIL reset_colors: got %h/%h want %h/%h", front_color, background_color, FG, BG);
        end else passed++;
        total++;
        if ({busy, frame_done, en_size} !== 3'b001) begin
            $display("FAIL reset_status: got busy/fd/en_size=%b want 001", {busy, frame_done, en_size});
        end else passed++;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        // Fill while init_done is low; out-of-range addresses must be ignored
        for (int a = 0; a < NC; a++) write_cell(a, 8'($urandom));
        for (int a = NC; a < 128; a++) write_cell(a, 8'($urandom));
        init_done = 1'b1;
        fl0 = flag_cnt;
        repeat (10) @(negedge sys_clk);
        total++;
        if (flag_cnt != fl0 || busy !== 1'b0) begin
            $display("FAIL idle_no_start: got flags=%0d busy=%b want 0 0", flag_cnt - fl0, busy);
        end else passed++;
    endtask

    task automatic test_frame();
        fl0 = flag_cnt; fd0 = fd_cnt;
        pulse_refresh();
        run_frame(NC, 1, 3, -1, -1, n, tmo, ust, bg_, bp, fw);
        total++;
        if (tmo || n != NC) $display("FAIL frame_count: got %0d cells tmo=%0b want %0d", n, tmo, NC);
        else passed++;
        for (int i = 0; i < n; i++) begin
            total++;
            if ({r_ascii[i], r_x[i], r_y[i], r_fg[i], r_bg[i]} !== exp_cell(i))
                $display("FAIL frame_cell[%0d]: got %h want %h", i, {r_ascii[i], r_x[i], r_y[i], r_fg[i], r_bg[i]}, exp_cell(i));
            else passed++;
        end
        total++;
        if (r_x[0] !== 9'd1 || r_y[0] !== 9'd0 || fw != 3)
            $display("FAIL frame_first: got x=%0d y=%0d latency=%0d want 1 0 3", r_x[0], r_y[0], fw);
        else passed++;
        total++;
        if (ust != 0 || bg_ != 0 || bp != 0)
            $display("FAIL frame_timing: got unstable=%0d badgap=%0d badpulse=%0d want 0", ust, bg_, bp);
        else passed++;
        repeat (20) @(negedge sys_clk);
        total++;
        if (fd_cnt - fd0 != 1 || busy !== 1'b0 || flag_cnt - fl0 != NC)
            $display("FAIL frame_end: got frame_done=%0d busy=%b flags=%0d want 1 0 %0d", fd_cnt - fd0, busy, flag_cnt - fl0, NC);
        else passed++;
    endtask

    task automatic test_attr();
        set_cursor(0, 1, 1);
        write_cell(20, 8'h05);
        write_cell(21, 8'h91);
        write_cell(22, 8'h06);
        pulse_refresh();
        run_frame(NC, 1, 2, -1, -1, n, tmo, ust, bg_, bp, fw);
        total++;
        if (tmo || {r_ascii[21], r_x[21], r_y[21], r_fg[21], r_bg[21]} !== {7'd17, 9'd9, 9'd16, HLF, HLB})
            $display("FAIL attr_cell21: got %h tmo=%0b want %h", {r_ascii[21], r_x[21], r_y[21], r_fg[21], r_bg[21]}, tmo, {7'd17, 9'd9, 9'd16, HLF, HLB});
        else passed++;
        total++;
        if ({r_fg[20], r_bg[20], r_fg[22], r_bg[22]} !== {FG, BG, FG, BG})
            $display("FAIL attr_neigh: got %h want %h", {r_fg[20], r_bg[20], r_fg[22], r_bg[22]}, {FG, BG, FG, BG});
        else passed++;
        repeat (5) @(negedge sys_clk);
    endtask

    task automatic test_cursor();
        set_cursor(1, 1, 1);
        pulse_refresh();
        run_frame(NC, 1, 2, -1, -1, n, tmo, ust, bg_, bp, fw);
        total++;
        if (tmo || {r_fg[21], r_bg[21]} !== {CF, CB})
            $display("FAIL cursor_on: got %h/%h tmo=%0b want %h/%h", r_fg[21], r_bg[21], tmo, CF, CB);
        else passed++;
        repeat (5) @(negedge sys_clk);
        set_cursor(0, 1, 1);
        pulse_refresh();
        run_frame(NC, 1, 2, -1, -1, n, tmo, ust, bg_, bp, fw);
        total++;
        if (tmo || {r_fg[21], r_bg[21]} !== {HLF, HLB})
            $display("FAIL cursor_off: got %h/%h tmo=%0b want %h/%h", r_fg[21], r_bg[21], tmo, HLF, HLB);
        else passed++;
        repeat (5) @(negedge sys_clk);
        // Random content with a random (possibly off-grid) cursor
        for (int j = 0; j < 20; j++) write_cell(int'($urandom_range(NC - 1, 0)), 8'($urandom));
        set_cursor(1, int'($urandom_range(ROWS, 0)), int'($urandom_range(COLS - 1, 0)));
        pulse_refresh();
        run_frame(NC, 1, 4, -1, -1, n, tmo, ust, bg_, bp, fw);
        for (int i = 0; i < n; i++) begin
            total++;
            if ({r_ascii[i], r_x[i], r_y[i], r_fg[i], r_bg[i]} !== exp_cell(i))
                $display("FAIL cursor_rand_cell[%0d]: got %h want %h", i, {r_ascii[i], r_x[i], r_y[i], r_fg[i], r_bg[i]}, exp_cell(i));
            else passed++;
        end
        total++;
        if (tmo || n != NC) $display("FAIL cursor_rand_count: got %0d want %0d", n, NC);
        else passed++;
        set_cursor(0, 0, 0);
        repeat (5) @(negedge sys_clk);
    endtask

    task automatic test_back_to_back();
        fl0 = flag_cnt; fd0 = fd_cnt;
        pulse_refresh();
        run_frame(NC, 1, 3, 30, 60, n, tmo, ust, bg_, bp, fw);
        total++;
        if (tmo || n != NC || busy !== 1'b1)
            $display("FAIL b2b_first: got %0d cells tmo=%0b busy=%b want %0d 0 1", n, tmo, busy, NC);
        else passed++;
        run_frame(NC, 1, 3, -1, -1, n, tmo, ust, bg_, bp, fw);
        for (int i = 0; i < n; i++) begin
            total++;
            if ({r_ascii[i], r_x[i], r_y[i], r_fg[i], r_bg[i]} !== exp_cell(i))
                $display("FAIL b2b_cell[%0d]: got %h want %h", i, {r_ascii[i], r_x[i], r_y[i], r_fg[i], r_bg[i]}, exp_cell(i));
            else passed++;
        end
        repeat (30) @(negedge sys_clk);
        total++;
        if (flag_cnt - fl0 != 2 * NC || fd_cnt - fd0 != 2 || busy !== 1'b0)
            $display("FAIL b2b_total: got flags=%0d frame_done=%0d busy=%b want %0d 2 0", flag_cnt - fl0, fd_cnt - fd0, busy, 2 * NC);
        else passed++;
    endtask

    task automatic test_init_drop();
        pulse_refresh();
        run_frame(10, 1, 3, -1, -1, n, tmo, ust, bg_, bp, fw);
        total++;
        if (tmo || n != 10 || busy !== 1'b1)
            $display("FAIL drop_pre: got %0d cells tmo=%0b busy=%b want 10 0 1", n, tmo, busy);
        else passed++;
        init_done = 1'b0;
        seen = 0;
        repeat (5) begin @(negedge sys_clk); if (show_char_flag !== 1'b0) seen++; end
        total++;
        if (seen != 0 || busy !== 1'b0)
            $display("FAIL drop_low: got flags=%0d busy=%b want 0 0", seen, busy);
        else passed++;
        init_done = 1'b1;
        repeat (10) begin @(negedge sys_clk); if (show_char_flag !== 1'b0) seen++; end
        total++;
        if (seen != 0) $display("FAIL drop_no_resume: got %0d flags want 0", seen);
        else passed++;
        pulse_refresh();
        run_frame(NC, 1, 3, -1, -1, n, tmo, ust, bg_, bp, fw);
        total++;
        if (tmo || n != NC || r_x[0] !== 9'd1 || r_y[0] !== 9'd0)
            $display("FAIL drop_restart: got n=%0d x=%0d y=%0d want %0d 1 0", n, r_x[0], r_y[0], NC);
        else passed++;
        for (int i = 0; i < n; i++) begin
            total++;
            if ({r_ascii[i], r_x[i], r_y[i], r_fg[i], r_bg[i]} !== exp_cell(i))
                $display("FAIL drop_cell[%0d]: got %h want %h", i, {r_ascii[i], r_x[i], r_y[i], r_fg[i], r_bg[i]}, exp_cell(i));
            else passed++;
        end
        repeat (5) @(negedge sys_clk);
        // A request made while init_done is low stays queued
        init_done = 1'b0;
        pulse_refresh();
        repeat (3) @(negedge sys_clk);
        total++;
        if (busy !== 1'b0) $display("FAIL drop_hold: got busy=%b want 0", busy);
        else passed++;
        init_done = 1'b1;
        run_frame(NC, 1, 2, -1, -1, n, tmo, ust, bg_, bp, fw);
        total++;
        if (tmo || n != NC) $display("FAIL drop_pending: got %0d cells tmo=%0b want %0d", n, tmo, NC);
        else passed++;
        repeat (5) @(negedge sys_clk);
    endtask

    task automatic test_async_reset();
        pulse_refresh();
        run_frame(5, 1, 3, -1, -1, n, tmo, ust, bg_, bp, fw);
        #2 sys_rst_n = 1'b0;
        #1;
        total++;
        if ({show_char_flag, busy, frame_done, ascii_num, start_x, start_y, front_color, background_color}
            !== {3'b000, 7'd0, 9'd0, 9'd0, FG, BG})
            $display("FAIL async_reset: got flag=%b busy=%b x=%0d y=%0d ascii=%0d fg=%h", show_char_flag, busy, start_x, start_y, ascii_num, front_color);
        else passed++;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        total++;
        if (busy !== 1'b0) $display("FAIL async_idle: got busy=%b want 0", busy);
        else passed++;
        pulse_refresh();
        run_frame(NC, 1, 2, -1, -1, n, tmo, ust, bg_, bp, fw);
        total++;
        if (tmo || n != NC) $display("FAIL async_frame: got %0d cells want %0d", n, NC);
        else passed++;
        for (int i = 0; i < n; i++) begin
            total++;
            if ({r_ascii[i], r_x[i], r_y[i], r_fg[i], r_bg[i]} !== exp_cell(i))
                $display("FAIL async_cell[%0d]: got %h want %h", i, {r_ascii[i], r_x[i], r_y[i], r_fg[i], r_bg[i]}, exp_cell(i));
            else passed++;
        end
        repeat (5) @(negedge sys_clk);
    endtask

    task automatic test_slow_done();
        pulse_refresh();
        run_frame(NC, 40, 40, -1, -1, n, tmo, ust, bg_, bp, fw);
        total++;
        if (tmo || n != NC) $display("FAIL slow_count: got %0d cells want %0d", n, NC);
        else passed++;
        total++;
        if (ust != 0 || bg_ != 0 || bp != 0)
            $display("FAIL slow_timing: got unstable=%0d badgap=%0d badpulse=%0d want 0", ust, bg_, bp);
        else passed++;
        repeat (5) @(negedge sys_clk);
    endtask

    initial begin
        test_reset();
        test_frame();
        test_attr();
        test_cursor();
        test_back_to_back();
        test_init_drop();
        test_async_reset();
        test_slow_done();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
        $fatal(1);
    end

endmodule
